// File: rtl/sseg_scan_capture_4dig.sv
// sseg_scan_capture_4dig
// Receiving end of a 4-digit multiplexed seven-segment scan bus. The scan is
// synchronized, filtered for stability and demultiplexed into four held digit
// registers. A complete frame is flagged once all four digits are seen.
// Illegal digit-enable patterns set a sticky error flag.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   en_dig_in    digit enables, active-low (one-hot-low when legal)
//   sseg_in      segments, active-low, bit7=dp, bits6:0=g..a
//   dig0..dig3   captured raw segment patterns (reset 8'hFF = blank)
//   frame_valid  all four digits captured since the last reset or timeout
//   frame_tick   one-clock pulse when the seen-mask completes
//   err_illegal  sticky; set on a stable illegal enable pattern
//   hex_val      (SSEG_DECODE_EN only) 4-bit decoded value per digit
//   hex_ok       (SSEG_DECODE_EN only) per-digit decode-match flag
//
// Optional feature macro: SSEG_DECODE_EN adds the hex decode outputs.
//
// FSM states:
//   state      | meaning
//   ST_SETTLE  | waiting for STABLE_CNT equal samples, then capture once
//   ST_HELD    | dwell already captured; wait for the input to change

module sseg_scan_capture_4dig #(
  parameter int STABLE_CNT = 4,
  parameter int TIMEOUT_W  = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] en_dig_in,
  input  logic [7:0] sseg_in,
  output logic [7:0] dig0,
  output logic [7:0] dig1,
  output logic [7:0] dig2,
  output logic [7:0] dig3,
  output logic       frame_valid,
  output logic       frame_tick,
  output logic       err_illegal
`ifdef SSEG_DECODE_EN
  ,
  output logic [15:0] hex_val,
  output logic [3:0]  hex_ok
`endif
);

  localparam logic [0:0] ST_SETTLE = 1'b0;
  localparam logic [0:0] ST_HELD   = 1'b1;

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CNT);
  localparam logic [7:0] STABLE_CAP = 8'(STABLE_CNT - 1);

  // Synchronizer and previous sample reset to the idle bus value (all
  // enables off, all segments off) so that the filter never sees a phantom
  // all-zero pattern right after reset.
  logic [11:0] sync1;
  logic [11:0] sync2;
  logic [11:0] prev;
  logic [7:0]  stab_cnt;
  logic [0:0]  state;
  logic [3:0]  seen_mask;
  logic [TIMEOUT_W-1:0] to_cnt;

  logic       same;
  logic       capture;
  logic [3:0] en_s;
  logic [7:0] seg_s;
  logic [3:0] sel;
  logic       legal_cap;
  logic       illegal_cap;
  logic [3:0] mask_next;
  logic       to_full;

  assign en_s    = sync2[11:8];
  assign seg_s   = sync2[7:0];
  assign same    = (sync2 == prev);
  assign capture = (state == ST_SETTLE) && same && (stab_cnt == STABLE_CAP);
  assign to_full = &to_cnt;

  always_comb begin
    sel = 4'b0000;
    case (en_s)
      4'b1110: sel = 4'b0001;
      4'b1101: sel = 4'b0010;
      4'b1011: sel = 4'b0100;
      4'b0111: sel = 4'b1000;
      default: sel = 4'b0000;
    endcase
  end

  assign legal_cap   = capture && (sel != 4'b0000);
  assign illegal_cap = capture && (sel == 4'b0000) && (en_s != 4'b1111);
  assign mask_next   = seen_mask | sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 12'hFFF;
      sync2 <= 12'hFFF;
    end else begin
      sync1 <= {en_dig_in, sseg_in};
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev     <= 12'hFFF;
      stab_cnt <= 8'd0;
      state    <= ST_SETTLE;
    end else begin
      prev <= sync2;
      if (!same)
        stab_cnt <= 8'd0;
      else if (stab_cnt != STABLE_MAX)
        stab_cnt <= stab_cnt + 8'd1;

      case (state)
        ST_SETTLE: if (capture) state <= ST_HELD;
        ST_HELD:   if (!same)   state <= ST_SETTLE;
        default:   state <= ST_SETTLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dig0        <= 8'hFF;
      dig1        <= 8'hFF;
      dig2        <= 8'hFF;
      dig3        <= 8'hFF;
      seen_mask   <= 4'b0000;
      frame_valid <= 1'b0;
      frame_tick  <= 1'b0;
      err_illegal <= 1'b0;
      to_cnt      <= '0;
    end else begin
      frame_tick <= 1'b0;
      if (illegal_cap)
        err_illegal <= 1'b1;

      // A legal capture takes priority over a coincident timeout.
      if (legal_cap) begin
        to_cnt <= '0;
        if (sel[0]) dig0 <= seg_s;
        if (sel[1]) dig1 <= seg_s;
        if (sel[2]) dig2 <= seg_s;
        if (sel[3]) dig3 <= seg_s;
        if (mask_next == 4'b1111) begin
          frame_tick  <= 1'b1;
          frame_valid <= 1'b1;
          seen_mask   <= 4'b0000;
        end else begin
          seen_mask <= mask_next;
        end
      end else if (to_full) begin
        frame_valid <= 1'b0;
        seen_mask   <= 4'b0000;
      end else begin
        to_cnt <= to_cnt + TIMEOUT_W'(1);
      end
    end
  end

`ifdef SSEG_DECODE_EN
  // Returns {match, value}; dp is not part of the pattern.
  function automatic logic [4:0] decode7(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h40: r = 5'h10;
      7'h79: r = 5'h11;
      7'h24: r = 5'h12;
      7'h30: r = 5'h13;
      7'h19: r = 5'h14;
      7'h12: r = 5'h15;
      7'h02: r = 5'h16;
      7'h78: r = 5'h17;
      7'h00: r = 5'h18;
      7'h10: r = 5'h19;
      7'h08: r = 5'h1A;
      7'h03: r = 5'h1B;
      7'h46: r = 5'h1C;
      7'h21: r = 5'h1D;
      7'h06: r = 5'h1E;
      7'h0E: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  logic [4:0] dec;
  assign dec = decode7(seg_s[6:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex_val <= 16'h0000;
      hex_ok  <= 4'b0000;
    end else if (legal_cap) begin
      for (int i = 0; i < 4; i++) begin
        if (sel[i]) begin
          hex_val[i*4 +: 4] <= dec[3:0];
          hex_ok[i]         <= dec[4];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_sseg_scan_capture_4dig.sv
// Testbench for sseg_scan_capture_4dig: directed scenarios followed by a
// randomized sequence of input dwells checked against a dwell-level model.
// Dwells are either short (never captured) or long (always captured).

module tb_sseg_scan_capture_4dig;

  localparam int SC = 4;
  localparam int TW = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] en_dig_in = 4'hF;
  logic [7:0] sseg_in = 8'hFF;
  logic [7:0] dig0, dig1, dig2, dig3;
  logic       frame_valid, frame_tick, err_illegal;
`ifdef SSEG_DECODE_EN
  logic [15:0] hex_val;
  logic [3:0]  hex_ok;
`endif

  sseg_scan_capture_4dig #(.STABLE_CNT(SC), .TIMEOUT_W(TW)) dut (
    .clk(clk),
    .reset(reset),
    .en_dig_in(en_dig_in),
    .sseg_in(sseg_in),
    .dig0(dig0),
    .dig1(dig1),
    .dig2(dig2),
    .dig3(dig3),
    .frame_valid(frame_valid),
    .frame_tick(frame_tick),
    .err_illegal(err_illegal)
`ifdef SSEG_DECODE_EN
    ,
    .hex_val(hex_val),
    .hex_ok(hex_ok)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;

  always @(negedge clk) if (frame_tick === 1'b1) tick_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model, one update per captured dwell.
  logic [7:0] m_dig [4];
  logic [3:0] m_mask;
  logic       m_valid;
  logic       m_err;
  int         m_ticks = 0;
  logic [3:0] m_hex [4];
  logic       m_hexok [4];
  logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_dig[i] = 8'hFF; m_hex[i] = 4'h0; m_hexok[i] = 1'b0;
    end
    m_mask = 4'h0; m_valid = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_capture(input logic [3:0] e, input logic [7:0] s);
    int d = -1;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] pat;
      pat = ~(4'b0001 << i);
      if (e == pat) d = i;
    end
    if (d >= 0) begin
      m_dig[d] = s;
      m_hex[d] = 4'h0; m_hexok[d] = 1'b0;
      for (int v = 0; v < 16; v++)
        if (font[v] == s[6:0]) begin m_hex[d] = 4'(v); m_hexok[d] = 1'b1; end
      m_mask[d] = 1'b1;
      if (m_mask == 4'hF) begin
        m_ticks++; m_valid = 1'b1; m_mask = 4'h0;
      end
    end else if (e != 4'hF) begin
      m_err = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] got [4];
    got = '{dig0, dig1, dig2, dig3};
    for (int i = 0; i < 4; i++)
      check($sformatf("%s dig%0d", tag, i), {24'h0, got[i]}, {24'h0, m_dig[i]});
    check({tag, " frame_valid"}, {31'h0, frame_valid}, {31'h0, m_valid});
    check({tag, " err_illegal"}, {31'h0, err_illegal}, {31'h0, m_err});
    check({tag, " ticks"}, tick_cnt, m_ticks);
`ifdef SSEG_DECODE_EN
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s hex%0d", tag, i), {28'h0, hex_val[i*4 +: 4]}, {28'h0, m_hex[i]});
      check($sformatf("%s hex_ok%0d", tag, i), {31'h0, hex_ok[i]}, {31'h0, m_hexok[i]});
    end
`endif
  endtask

  task automatic dwell(input logic [3:0] e, input logic [7:0] s, input int n);
    en_dig_in = e;
    sseg_in   = s;
    repeat (n) @(negedge clk);
  endtask

  // Long enough (>= SC+4 clocks) to be captured with margin.
  task automatic long_dwell(input logic [3:0] e, input logic [7:0] s, input int n);
    dwell(e, s, n);
    model_capture(e, s);
  endtask

  function automatic logic [3:0] legal_en(input int d);
    logic [3:0] one;
    one = 4'b0001 << d;
    return ~one;
  endfunction

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    check("reset tick", {31'h0, frame_tick}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Unstable segments on digit 0 never settle.
    for (int k = 0; k < 20; k++) dwell(4'b1110, (k % 2 == 0) ? 8'hC0 : 8'hF9, 2);
    dwell(4'hF, 8'hFF, 2);
    check_all("toggle");
    check("toggle dig0 blank", {24'h0, dig0}, 32'hFF);

    // Clean full frame.
    long_dwell(4'b1110, 8'hC0, 20);
    long_dwell(4'b1101, 8'hF9, 20);
    long_dwell(4'b1011, 8'hA4, 20);
    check("no tick before dig3", tick_cnt, 0);
    long_dwell(4'b0111, 8'hB0, 20);
    check_all("frame1");
    check("frame1 tick once", tick_cnt, 1);

    // Stable illegal enable pattern.
    long_dwell(4'b1001, 8'h00, 10);
    check_all("illegal");
    long_dwell(4'hF, 8'hFF, 4);
    check("illegal sticky", {31'h0, err_illegal}, 32'h1);
    long_dwell(4'b1110, 8'h99, 12);
    long_dwell(4'b1101, 8'h92, 12);
    long_dwell(4'b1011, 8'h82, 12);
    long_dwell(4'b0111, 8'hF8, 12);
    check_all("after_illegal");

    // Inactivity timeout drops frame_valid but keeps digits.
    long_dwell(4'hF, 8'hFF, 30);
    check_all("pre_timeout");
    dwell(4'hF, 8'hFF, 50);
    m_valid = 1'b0; m_mask = 4'h0;
    check_all("timeout");

    // Reset mid-dwell after two digits.
    long_dwell(4'b1110, 8'h80, 12);
    dwell(4'b1101, 8'h90, 12);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    check("async_reset tick", {31'h0, frame_tick}, 32'h0);
    en_dig_in = 4'hF; sseg_in = 8'hFF;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    dwell(4'hF, 8'hFF, 4);
    long_dwell(4'b1011, 8'hC6, 12);
    long_dwell(4'b0111, 8'hA1, 12);
    check_all("post_reset_half");
    long_dwell(4'b1110, 8'h86, 12);
    long_dwell(4'b1101, 8'h8E, 12);
    check_all("post_reset_full");

`ifdef SSEG_DECODE_EN
    long_dwell(4'b1011, 8'h88, 12);
    long_dwell(4'b1110, 8'h8E, 12);
    long_dwell(4'b1101, 8'hFF, 12);
    check("dec hex2", {28'h0, hex_val[11:8]}, 32'hA);
    check("dec hex0", {28'h0, hex_val[3:0]}, 32'hF);
    check("dec ok2", {31'h0, hex_ok[2]}, 32'h1);
    check("dec ok0", {31'h0, hex_ok[0]}, 32'h1);
    check("dec ok1", {31'h0, hex_ok[1]}, 32'h0);
    check_all("decode");
`endif

    // Randomized dwells.
    begin
      logic [3:0] cur_e;
      logic [7:0] cur_s;
      int gap;
      cur_e = en_dig_in; cur_s = sseg_in; gap = 0;
      for (int n = 0; n < 150; n++) begin
        int r;
        logic [3:0] e;
        logic [7:0] s;
        bit lng;
        r = (gap > 20) ? 0 : int'($urandom_range(0, 99));
        s = 8'($urandom);
        if (r < 60 || r >= 95) begin
          e = legal_en(int'($urandom_range(0, 3)));
          if ($urandom_range(0, 1) == 1) s = {1'b1, font[$urandom_range(0, 15)]};
          lng = 1;
        end else if (r < 80) begin
          e = 4'($urandom); lng = 0;
        end else if (r < 90) begin
          e = 4'hF; lng = 1;
        end else begin
          do e = 4'($urandom);
          while (e == 4'hF || e == 4'hE || e == 4'hD || e == 4'hB || e == 4'h7);
          lng = 1;
        end
        if (e == cur_e && s == cur_s) s = s ^ 8'h01;
        cur_e = e; cur_s = s;
        if (lng) begin
          int len;
          len = int'($urandom_range(8, 12));
          long_dwell(e, s, len);
          if (e == 4'hE || e == 4'hD || e == 4'hB || e == 4'h7) gap = len;
          else gap += len;
          check_all($sformatf("rand%0d", n));
        end else begin
          int len;
          len = int'($urandom_range(1, SC));
          dwell(e, s, len);
          gap += len;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sseg_scan_capture_4dig.md
Name: sseg_scan_capture_4dig

Overview:
- Receiving end of the 4-digit multiplexed seven-segment scan bus.
- Samples an externally driven scan (active-low digit enables plus active-low segment byte) and demultiplexes it back into four held digit registers.
- Flags a complete frame once all four digits are captured; flags illegal enable patterns.
- Used for board-to-board display mirroring and for self-checking the display driver in loopback.

Parameters:
STABLE_CNT, 4, consecutive equal synchronized samples required before a capture (valid range 1..255).
TIMEOUT_W, 20, width of the inactivity counter; no capture for 2^TIMEOUT_W-1 clocks drops frame_valid.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
en_dig_in  input  4  scanned digit enables, active-low, one-hot-low when legal
sseg_in  input  8  scanned segments, active-low; bit7=dp, bits6:0=g..a
dig0  output  8  captured pattern for digit 0 (en 4'b1110), raw active-low
dig1  output  8  captured pattern for digit 1 (en 4'b1101)
dig2  output  8  captured pattern for digit 2 (en 4'b1011)
dig3  output  8  captured pattern for digit 3 (en 4'b0111)
frame_valid  output  1  all four digits captured since the last reset or timeout
frame_tick  output  1  one-clock pulse each time the seen-mask completes
err_illegal  output  1  sticky; set on a stable illegal enable pattern

Behaviour:
- Reset values: dig0..dig3=8'hFF (blank), frame_valid=0, frame_tick=0, err_illegal=0, seen-mask=0, FSM=SETTLE, counters=0.
- Reset is asynchronous and active-high; assertion mid-operation clears all state immediately.
- Synchronization:
  - Two-flop synchronizer on all 12 input bits.
  - All further logic uses the synchronized value S={en,sseg}.
- Stability filter:
  - Keep the previous sample P and a stability counter C.
  - When S!=P, C is set to 0.
  - When S==P, C increments, saturating at STABLE_CNT.
- FSM:
  - SETTLE: when C reaches STABLE_CNT-1 with S==P, perform a capture action and go to HELD.
  - HELD: stay while S==P. On S!=P go to SETTLE. No second capture of the same dwell.
- Capture action, by en:
  - 1110/1101/1011/0111: load sseg into dig0/1/2/3 and set the matching seen-mask bit.
  - 1111: blanking interval; no load, no error.
  - Any other value: set err_illegal; no load.
- Latency: a clean input change appears on dig* STABLE_CNT+2 clocks later, with +1 clock of async sampling uncertainty.
- Frame completion:
  - When the seen-mask becomes 4'b1111, pulse frame_tick for one clock, set frame_valid, and clear the mask in the same clock.
  - Recapturing a digit already in the mask overwrites dig* and leaves the mask unchanged.
- Timeout:
  - The counter clears on every legal capture and otherwise increments, saturating at all-ones.
  - On reaching all-ones: frame_valid=0 and seen-mask=0. dig* hold their last values.
  - If a capture and the timeout occur in the same clock, the capture wins.
- err_illegal clears only on reset.

Optional Feature:
- Macro: SSEG_DECODE_EN.
- Defined:
  - Adds outputs hex_val (16 bits, 4 per digit, digit0 in bits 3:0) and hex_ok (4 bits).
  - Each legal capture also decodes the active-low pattern (dp ignored) to 0..F using the standard gfedcba map, e.g. 0=7'h40, 1=7'h79, 8=7'h00, A=7'h08, F=7'h0E.
  - An unmatched pattern gives hex_ok bit=0 and hex nibble=0.
  - Decode results are registered alongside dig*. Reset: hex_val=0, hex_ok=0.
- Undefined: these ports and the decode logic are absent.

Test Plan:
- Drive a legal scan with each digit held 20 clocks, dig0..3=C0,F9,A4,B0 -> dig* match; frame_tick pulses once after the dig3 capture; frame_valid=1.
- Hold en=1110 with sseg toggling between C0 and F9 every 2 clocks, STABLE_CNT=4 -> dig0 stays FF; no capture.
- Hold en=1001 stable for 10 clocks -> err_illegal=1 and stays 1; dig* unchanged. Later legal scans still capture.
- Complete one frame, then hold en=1111 for 2^TIMEOUT_W clocks (TIMEOUT_W=6 in sim) -> frame_valid falls to 0; dig* keep their values.
- Assert reset mid-dwell after two digits are captured -> all outputs return to reset values. The next full scan needs four fresh captures before frame_tick.
- With SSEG_DECODE_EN, capture 88 on digit2 and 8E on digit0 -> hex_val[11:8]=A, hex_val[3:0]=F, hex_ok bits 2 and 0 =1. Capture FF on digit1 -> hex_ok[1]=0.
